// File: rtl/data_cache_if.sv
// CPU-side and memory-side signal bundle for the direct-mapped data cache.
// Latency: none, wires only.
// Backpressure: BUSYWAIT stalls the CPU; MEM_BUSYWAIT stalls the cache.
interface data_cache_if;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    // Cache side: consumes CPU requests and memory responses.
    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );

    // Environment side: CPU plus main memory.
    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped 8-line cache of 4-byte blocks with write-back, write-allocate policy.
// Latency: hits resolve combinationally; misses take 1 + memory cycles (+ writeback cycles if dirty).
// Backpressure: BUSYWAIT stalls the CPU during a miss; each memory phase waits for MEM_BUSYWAIT=0.
module data_cache (
    input  logic           CLK,
    input  logic           RESET,
    data_cache_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Valid/dirty are reset; tags and data are left as-is since valid gates them.
    logic [7:0]  valid;
    logic [7:0]  dirty;
    logic [2:0]  tag_mem  [8];
    logic [31:0] data_mem [8];

    logic [2:0]  req_tag;
    logic [2:0]  idx;
    logic [1:0]  off;
    logic        req;
    logic        hit;
    logic [31:0] line;
    logic        fill_done;
    logic        wb_done;
    logic        wr_hit;

    assign req_tag = bus.ADDRESS[7:5];
    assign idx     = bus.ADDRESS[4:2];
    assign off     = bus.ADDRESS[1:0];
    assign req     = bus.READ | bus.WRITE;
    assign line    = data_mem[idx];
    assign hit     = valid[idx] & (tag_mem[idx] == req_tag);

    // A WRITE with READ also high is treated as a store.
    assign wr_hit    = (state == IDLE) & bus.WRITE & hit;
    assign fill_done = (state == FETCH) & ~bus.MEM_BUSYWAIT;
    assign wb_done   = (state == WRITEBACK) & ~bus.MEM_BUSYWAIT;

    // Load data is the addressed byte of the indexed line; only meaningful on an IDLE hit.
    assign bus.READDATA = line[{off, 3'b000} +: 8];

    // State register; reset drops straight to IDLE, abandoning any memory transaction.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and memory/CPU handshake outputs.
    always_comb begin
        state_nxt         = state;
        bus.BUSYWAIT      = 1'b0;
        bus.MEM_READ      = 1'b0;
        bus.MEM_WRITE     = 1'b0;
        bus.MEM_ADDRESS   = 6'd0;
        bus.MEM_WRITEDATA = 32'd0;
        case (state)
            IDLE: begin
                if (req && !hit) begin
                    bus.BUSYWAIT = 1'b1;
                    state_nxt    = (valid[idx] && dirty[idx]) ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                bus.BUSYWAIT      = 1'b1;
                bus.MEM_WRITE     = 1'b1;
                bus.MEM_ADDRESS   = {tag_mem[idx], idx};
                bus.MEM_WRITEDATA = line;
                // If the CPU has withdrawn its request there is nothing to fetch.
                if (!bus.MEM_BUSYWAIT) begin
                    state_nxt = req ? FETCH : IDLE;
                end
            end
            FETCH: begin
                bus.BUSYWAIT    = 1'b1;
                bus.MEM_READ    = 1'b1;
                bus.MEM_ADDRESS = {req_tag, idx};
                if (!bus.MEM_BUSYWAIT) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Line status: a fill makes the line valid and clean, a finished writeback
    // leaves it clean, a store hit marks it dirty.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid <= 8'd0;
            dirty <= 8'd0;
        end else if (fill_done) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (wb_done) begin
            dirty[idx] <= 1'b0;
        end else if (wr_hit) begin
            dirty[idx] <= 1'b1;
        end
    end

    // Tag and data arrays: block load on fill completion, byte merge on store hit.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tag_mem[idx]  <= req_tag;
            data_mem[idx] <= bus.MEM_READDATA;
        end else if (wr_hit) begin
            data_mem[idx][{off, 3'b000} +: 8] <= bus.WRITEDATA;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache against a 5-cycle main-memory model.
// Latency: memory latches a request on its first edge, then stays busy 5 cycles.
// Backpressure: the memory model drives MEM_BUSYWAIT; the CPU side waits on BUSYWAIT.
module tb_data_cache;

    logic clk;
    logic rst_n;
    data_cache_if bus ();

    data_cache dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main memory model: 64 blocks.
    logic [31:0] mem [64];
    int          mem_cnt;

    assign bus.MEM_READDATA = mem[bus.MEM_ADDRESS];
    assign bus.MEM_BUSYWAIT = (bus.MEM_READ | bus.MEM_WRITE) && (mem_cnt != 5);

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[6'h09] = 32'hDDCCBBAA;
        mem[6'h29] = 32'h44332211;
        mem[6'h02] = 32'h0F0E0D0C;
        mem[6'h11] = 32'h87654321;
        mem[6'h19] = 32'hF0E1D2C3;
        mem_cnt = 0;
        forever begin
            @(posedge clk);
            if (bus.MEM_READ | bus.MEM_WRITE) begin
                if (mem_cnt == 5) begin
                    mem_cnt <= 0;
                    if (bus.MEM_WRITE) mem[bus.MEM_ADDRESS] <= bus.MEM_WRITEDATA;
                end else begin
                    mem_cnt <= mem_cnt + 1;
                end
            end else begin
                mem_cnt <= 0;
            end
        end
    end

    // Bus monitor: latest memory-side values and cycle counts per phase.
    logic        both_seen = 1'b0;
    int          wb_cycles = 0;
    int          rd_cycles = 0;
    logic [5:0]  wb_addr   = 6'd0;
    logic [31:0] wb_data   = 32'd0;
    logic [5:0]  rd_addr   = 6'd0;

    always @(negedge clk) begin
        if (bus.MEM_READ && bus.MEM_WRITE) both_seen = 1'b1;
        if (bus.MEM_WRITE) begin
            wb_cycles = wb_cycles + 1;
            wb_addr   = bus.MEM_ADDRESS;
            wb_data   = bus.MEM_WRITEDATA;
        end
        if (bus.MEM_READ) begin
            rd_cycles = rd_cycles + 1;
            rd_addr   = bus.MEM_ADDRESS;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One CPU access: counts stalled edges, captures READDATA, then allows one
    // more edge (commits a store hit) before dropping the request.
    task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                          input logic [7:0] d, output int edges, output logic [7:0] rdata);
        @(negedge clk);
        bus.READ      = rd;
        bus.WRITE     = wr;
        bus.ADDRESS   = a;
        bus.WRITEDATA = d;
        #1;
        edges = 0;
        while (bus.BUSYWAIT === 1'b1 && edges < 100) begin
            edges++;
            @(posedge clk);
            #1;
        end
        rdata = bus.READDATA;
        @(posedge clk);
        #1;
        bus.READ  = 1'b0;
        bus.WRITE = 1'b0;
    endtask

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         edges;
        logic [7:0] rdata;
        logic [5:0] maddr;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         e;
        int         n;
        int         wb0;
        logic [7:0] r;

        tbl[0] = '{1'b1, 1'b0, 8'h25, 8'h00, 7, 8'hBB, 6'h09};
        tbl[1] = '{1'b0, 1'b1, 8'h25, 8'h5A, 0, 8'h00, 6'h09};
        tbl[2] = '{1'b1, 1'b0, 8'h25, 8'h00, 0, 8'h5A, 6'h09};
        tbl[3] = '{1'b1, 1'b0, 8'h24, 8'h00, 0, 8'hAA, 6'h09};
        tbl[4] = '{1'b1, 1'b0, 8'h26, 8'h00, 0, 8'hCC, 6'h09};
        tbl[5] = '{1'b1, 1'b0, 8'h27, 8'h00, 0, 8'hDD, 6'h09};
        tbl[6] = '{1'b1, 1'b0, 8'h08, 8'h00, 7, 8'h0C, 6'h02};
        tbl[7] = '{1'b1, 1'b0, 8'h0B, 8'h00, 0, 8'h0F, 6'h02};
        tbl[8] = '{1'b0, 1'b0, 8'h25, 8'h00, 0, 8'h00, 6'h02};

        rst_n         = 1'b0;
        bus.READ      = 1'b0;
        bus.WRITE     = 1'b0;
        bus.ADDRESS   = 8'h00;
        bus.WRITEDATA = 8'h00;
        #12;
        check("rst_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
        check("rst_mem_read", {31'd0, bus.MEM_READ}, 32'd0);
        check("rst_mem_write", {31'd0, bus.MEM_WRITE}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);

        // Fills, store hit, byte selection and idle cycle.
        for (int i = 0; i < 9; i++) begin
            wb0 = wb_cycles;
            access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, e, r);
            check($sformatf("vec%0d_edges", i), e, tbl[i].edges);
            check($sformatf("vec%0d_no_wb", i), wb_cycles - wb0, 0);
            if (tbl[i].rd && !tbl[i].wr)
                check($sformatf("vec%0d_rdata", i), {24'd0, r}, {24'd0, tbl[i].rdata});
            if (tbl[i].edges > 0)
                check($sformatf("vec%0d_maddr", i), {26'd0, rd_addr}, {26'd0, tbl[i].maddr});
        end

        // Conflict miss on the dirty line: writeback then fetch.
        wb0 = wb_cycles;
        access(1'b1, 1'b0, 8'hA5, 8'h00, e, r);
        check("evict_edges", e, 13);
        check("evict_wb_cycles", wb_cycles - wb0, 6);
        check("evict_wb_addr", {26'd0, wb_addr}, 32'h09);
        check("evict_wb_data", wb_data, 32'hDDCC5AAA);
        check("evict_fetch_addr", {26'd0, rd_addr}, 32'h29);
        check("evict_rdata", {24'd0, r}, 32'h22);
        check("evict_mem_block", mem[6'h09], 32'hDDCC5AAA);

        // Reset asserted in the middle of a fetch.
        @(negedge clk);
        bus.READ    = 1'b1;
        bus.ADDRESS = 8'h25;
        @(posedge clk);
        #1;
        check("rstfetch_started", {31'd0, bus.MEM_READ}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstfetch_mem_read", {31'd0, bus.MEM_READ}, 32'd0);
        check("rstfetch_mem_write", {31'd0, bus.MEM_WRITE}, 32'd0);
        check("rstfetch_idle_miss", {31'd0, bus.BUSYWAIT}, 32'd1);
        bus.READ = 1'b0;
        #1;
        check("rstfetch_no_req", {31'd0, bus.BUSYWAIT}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b1, 1'b0, 8'h25, 8'h00, e, r);
        check("rstfetch_reread_edges", e, 7);
        check("rstfetch_reread_rdata", {24'd0, r}, 32'h5A);

        // Request withdrawn during a fetch: fill still completes.
        @(negedge clk);
        bus.READ    = 1'b1;
        bus.ADDRESS = 8'h47;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.READ = 1'b0;
        n = 0;
        while (bus.BUSYWAIT === 1'b1 && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("drop_fill_edges", n, 6);
        check("drop_fetch_addr", {26'd0, rd_addr}, 32'h11);
        access(1'b1, 1'b0, 8'h47, 8'h00, e, r);
        check("drop_hit_edges", e, 0);
        check("drop_hit_rdata", {24'd0, r}, 32'h87);

        // READ and WRITE together act as a store.
        access(1'b1, 1'b1, 8'h47, 8'h3C, e, r);
        check("rw_edges", e, 0);
        access(1'b1, 1'b0, 8'h47, 8'h00, e, r);
        check("rw_readback", {24'd0, r}, 32'h3C);
        wb0 = wb_cycles;
        access(1'b1, 1'b0, 8'h67, 8'h00, e, r);
        check("rw_evict_edges", e, 13);
        check("rw_evict_wb_cycles", wb_cycles - wb0, 6);
        check("rw_evict_wb_addr", {26'd0, wb_addr}, 32'h11);
        check("rw_evict_wb_data", wb_data, 32'h3C654321);
        check("rw_evict_rdata", {24'd0, r}, 32'hF0);

        check("mem_rd_wr_exclusive", {31'd0, both_seen}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The block SHALL expose these ports, one per line, with clock and reset first:
- CLK  input  1  single clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- READ  input  1  CPU load request (from control unit READ_DATA_MEM).
- WRITE  input  1  CPU store request (from control unit WRITE_DATA_MEM).
- ADDRESS  input  8  CPU byte address: tag [7:5], index [4:2], offset [1:0].
- WRITEDATA  input  8  CPU store byte.
- READDATA  output  8  CPU load byte.
- BUSYWAIT  output  1  CPU stall request.
- MEM_READ  output  1  main-memory block read request.
- MEM_WRITE  output  1  main-memory block write request.
- MEM_ADDRESS  output  6  main-memory block address {tag,index}.
- MEM_WRITEDATA  output  32  block written back to memory.
- MEM_READDATA  input  32  block returned by memory.
- MEM_BUSYWAIT  input  1  memory busy; transaction completes on a rising edge where it is 0.

REQ-002 Geometry SHALL be fixed, with no parameters:
- Direct-mapped, 8 lines.
- 4-byte blocks; byte k of a block at bits [8k+7:8k].
- Per line: 3-bit tag, valid bit, dirty bit.

Function
REQ-003 hit SHALL be valid[index] & (tag[index]==ADDRESS[7:5]), evaluated combinationally.

REQ-004 FSM states SHALL be IDLE, WRITEBACK, FETCH.

REQ-005 In IDLE, BUSYWAIT SHALL equal (READ|WRITE) & ~hit, combinationally.

REQ-006 Read hit SHALL have zero stall: READDATA = selected byte combinationally, BUSYWAIT=0.

REQ-007 Write hit SHALL:
- Write WRITEDATA into the selected byte at the next rising edge.
- Set dirty[index]=1.
- Keep BUSYWAIT=0.

REQ-008 Miss, line clean or invalid: IDLE -> FETCH at the next edge.

REQ-009 Miss, line valid and dirty: IDLE -> WRITEBACK at the next edge.

REQ-010 WRITEBACK SHALL:
- Drive MEM_WRITE=1, MEM_ADDRESS={tag[index],index}, MEM_WRITEDATA=block[index].
- Go to FETCH on an edge where MEM_BUSYWAIT=0.

REQ-011 FETCH SHALL:
- Drive MEM_READ=1, MEM_ADDRESS={ADDRESS[7:5],index}.
- On an edge where MEM_BUSYWAIT=0: load MEM_READDATA into the block, set tag=ADDRESS[7:5], valid=1, dirty=0, and go to IDLE.

REQ-012 After FETCH the access SHALL re-resolve as a hit in IDLE. Miss latency SHALL be 1 + memory cycles, plus the writeback cycles if the line was dirty.

REQ-013 BUSYWAIT SHALL be 1 throughout WRITEBACK and FETCH.

REQ-014 MEM_READ and MEM_WRITE SHALL never both be 1. Outside the states in REQ-010/011 they SHALL be 0.

REQ-015 READ and WRITE both 1 SHALL be handled as WRITE; READDATA then has no defined value.

REQ-016 If READ/WRITE is deasserted mid-miss, the current memory transaction SHALL complete and the FSM SHALL return to IDLE without a CPU-side write.

REQ-017 With no request, BUSYWAIT SHALL be 0 and the cache state SHALL be unchanged.

REQ-018 READDATA SHALL reflect the addressed byte whenever the state is IDLE and there is a hit; otherwise its value is undefined.

Reset
REQ-019 RESET=0 SHALL immediately, asynchronously:
- Set the state to IDLE.
- Clear all valid and dirty bits.
- Force MEM_READ=0 and MEM_WRITE=0.
Tags and data are not cleared.

REQ-020 After RESET, BUSYWAIT SHALL be 0 when there is no request.

REQ-021 Reset mid-WRITEBACK or mid-FETCH SHALL abort the transaction with no block update. The first access after reset SHALL be a miss.

Verification
REQ-022 The bench SHALL cover these directed scenarios, with memory latency 5 cycles:
- Cold read ADDRESS=0x25, memory block=0xDDCCBBAA:
  - BUSYWAIT=1 for 7 edges.
  - MEM_ADDRESS=0x09.
  - Then READDATA=0xBB, BUSYWAIT=0.
- Write 0x5A to 0x25 after that fill:
  - No stall.
  - Subsequent read of 0x25 returns 0x5A.
  - dirty[1]=1.
- Read 0xA5 (same index, tag 5) after the dirty write:
  - WRITEBACK with MEM_WRITE=1, MEM_ADDRESS=0x09, MEM_WRITEDATA=0xDDCC5AAA.
  - Then FETCH with MEM_ADDRESS=0x29.
  - MEM_READ and MEM_WRITE are never both 1.
- RESET low during FETCH:
  - MEM_READ=0 the same instant; state IDLE.
  - Re-read of 0x25 misses again.
- READ deasserted during FETCH:
  - Fill completes; BUSYWAIT=0.
  - Next read of the same address hits with zero stall.
- READ=WRITE=1 at 0x25 on a hit line: byte updated, dirty set.
